// File: rtl/issue_cdb_scheduler_pkg.sv
// Shared types and defaults for the CDB issue scheduler and its priority-order helper.
package issue_cdb_scheduler_pkg;

    localparam int unsigned NUM_UNITS = 4;
    localparam int unsigned UNIT_W    = 2;
    localparam int unsigned CNT_W     = 16;

    localparam int unsigned DEF_INT_LAT  = 1;
    localparam int unsigned DEF_MUL_LAT  = 3;
    localparam int unsigned DEF_DIV_LAT  = 4;
    localparam int unsigned DEF_LDST_LAT = 2;
    localparam int unsigned DEF_MAX_LAT  = 4;

    typedef enum logic [UNIT_W-1:0] {
        UNIT_INT  = 2'd0,
        UNIT_MUL  = 2'd1,
        UNIT_DIV  = 2'd2,
        UNIT_LDST = 2'd3
    } unit_e;

    // Entry 0 is the highest-priority unit.
    typedef logic [NUM_UNITS-1:0][UNIT_W-1:0] prio_order_t;

endpackage

// File: rtl/issue_cdb_scheduler_prio_order.sv
// Priority order for the slot-claiming walk: rotating from ptr when ISSUE_RR_EN
// is defined, otherwise the fixed DIV > MUL > LDST > INT order.
module issue_prio_order
    import issue_cdb_scheduler_pkg::*;
(
`ifdef ISSUE_RR_EN
    input  logic [UNIT_W-1:0] ptr,
`endif
    output prio_order_t       prio
);

`ifdef ISSUE_RR_EN
    // Pointer is the head; remaining units follow in index order, wrapping.
    always_comb begin
        prio = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            prio[i[UNIT_W-1:0]] = ptr + i[UNIT_W-1:0];
        end
    end
`else
    assign prio = {UNIT_INT, UNIT_LDST, UNIT_MUL, UNIT_DIV};
`endif

endmodule

// File: rtl/issue_cdb_scheduler.sv
// Grants issue-queue reads only into free future CDB slots and flags CDB collisions.
// Optional rotating priority is enabled with the ISSUE_RR_EN macro.
module issue_cdb_scheduler
    import issue_cdb_scheduler_pkg::*;
#(
    parameter int unsigned INT_LAT  = DEF_INT_LAT,
    parameter int unsigned MUL_LAT  = DEF_MUL_LAT,
    parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
    parameter int unsigned LDST_LAT = DEF_LDST_LAT,
    parameter int unsigned MAX_LAT  = DEF_MAX_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [NUM_UNITS-1:0] queue_rdy,
    input  logic [NUM_UNITS-1:0] cdb_valid_in,
    output logic [NUM_UNITS-1:0] grant,
    output logic [MAX_LAT-1:0]   slot_busy,
    output logic                 collision_err,
    output logic [CNT_W-1:0]     grant_cnt
);

    if (INT_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1 || LDST_LAT < 1 ||
        INT_LAT > MAX_LAT || MUL_LAT > MAX_LAT || DIV_LAT > MAX_LAT || LDST_LAT > MAX_LAT)
    begin : g_bad_lat
        $error("issue_cdb_scheduler: every unit latency must be in 1..MAX_LAT");
    end

    // Bit k-1 of a slot mask stands for the CDB cycle k cycles from now.
    localparam logic [MAX_LAT-1:0] INT_SLOT  = MAX_LAT'(1) << (INT_LAT - 1);
    localparam logic [MAX_LAT-1:0] MUL_SLOT  = MAX_LAT'(1) << (MUL_LAT - 1);
    localparam logic [MAX_LAT-1:0] DIV_SLOT  = MAX_LAT'(1) << (DIV_LAT - 1);
    localparam logic [MAX_LAT-1:0] LDST_SLOT = MAX_LAT'(1) << (LDST_LAT - 1);

    function automatic logic [MAX_LAT-1:0] slot_mask(input logic [UNIT_W-1:0] u);
        logic [MAX_LAT-1:0] m;
        case (u)
            UNIT_INT: m = INT_SLOT;
            UNIT_MUL: m = MUL_SLOT;
            UNIT_DIV: m = DIV_SLOT;
            default:  m = LDST_SLOT;
        endcase
        return m;
    endfunction

    logic [MAX_LAT-1:0] res_q;
    logic [MAX_LAT-1:0] res_d;
    logic [MAX_LAT-1:0] claim;
    logic [MAX_LAT-1:0] cur_mask;
    logic [UNIT_W-1:0]  cur_unit;
    prio_order_t        prio;

`ifdef ISSUE_RR_EN
    logic [UNIT_W-1:0]  ptr_q;
    logic [UNIT_W-1:0]  first_unit;
    logic               first_vld;

    issue_prio_order u_prio (
        .ptr  (ptr_q),
        .prio (prio)
    );
`else
    issue_prio_order u_prio (
        .prio (prio)
    );
`endif

    // Walk units in priority order; each grant claims its slot so a later
    // unit with the same latency sees it as taken.
    always_comb begin
        grant    = '0;
        claim    = '0;
        cur_unit = '0;
        cur_mask = '0;
`ifdef ISSUE_RR_EN
        first_vld  = 1'b0;
        first_unit = '0;
`endif
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            cur_unit = prio[i[UNIT_W-1:0]];
            cur_mask = slot_mask(cur_unit);
            if (!rst && !stall && queue_rdy[cur_unit] &&
                ((res_q | claim) & cur_mask) == '0) begin
                grant[cur_unit] = 1'b1;
                claim           = claim | cur_mask;
`ifdef ISSUE_RR_EN
                if (!first_vld) begin
                    first_vld  = 1'b1;
                    first_unit = cur_unit;
                end
`endif
            end
        end
    end

    // New bookings join the vector, then everything moves one cycle closer;
    // the slot being retired (and any latency-1 claim) drops off the end.
    assign res_d = (res_q | claim) >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q         <= '0;
            collision_err <= 1'b0;
            grant_cnt     <= '0;
        end else begin
            res_q         <= res_d;
            collision_err <= collision_err | ($countones(cdb_valid_in) > 1);
            grant_cnt     <= grant_cnt + CNT_W'($countones(grant));
        end
    end

`ifdef ISSUE_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= UNIT_INT;
        end else if (first_vld) begin
            ptr_q <= first_unit + UNIT_W'(1);
        end
    end
`endif

    assign slot_busy = res_q;

endmodule
